// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state type and frame timing constants for the UART receive engine.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_e;

    localparam int TICKS_PER_BIT     = 4;
    localparam int START_SAMPLE_TICK = 2;
    localparam int DATA_BITS         = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO; a pop in the same cycle frees a slot so a push to a full FIFO still lands.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receive engine with 4x-baud sampling, byte FIFO and RTS flow control.
// Optional 3-sample majority filter on the synchronised input when UART_RX_GLITCH_FILTER_EN is defined.
module uart_rx_engine
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_MARGIN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_clk4x,
    input  logic       rx,
    input  logic       data_read,
    input  logic       err_clr,
    output logic [7:0] rxdata,
    output logic       rxrecv,
    output logic       rts,
    output logic       overrun,
    output logic       frame_err
);
    localparam int         CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] BIT_LAST   = 2'(TICKS_PER_BIT - 1);
    localparam logic [1:0] START_LAST = 2'(START_SAMPLE_TICK - 1);
    localparam logic [2:0] IDX_LAST   = 3'(DATA_BITS - 1);

    rx_state_e   state_q;
    logic [1:0]  tick_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        rx_meta_q, rx_s_q, rx_v;
    logic        dr_q, pop, push, stop_tick, ovf, ferr;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d, rts_q, rts_d;
    logic        empty, full;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], rx_s_q};

    assign rx_v = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_v = rx_s_q;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else if (bit_clk4x) begin
            case (state_q)
                S_IDLE:
                    if (!rx_v) begin
                        state_q <= S_START;
                        tick_q  <= '0;
                    end
                S_START:
                    if (tick_q == START_LAST) begin
                        state_q <= rx_v ? S_IDLE : S_DATA;
                        tick_q  <= '0;
                        idx_q   <= '0;
                    end else begin
                        tick_q <= tick_q + 2'd1;
                    end
                S_DATA: begin
                    tick_q <= tick_q + 2'd1;
                    if (tick_q == BIT_LAST) begin
                        shift_q[idx_q] <= rx_v;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == IDX_LAST) state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    tick_q <= tick_q + 2'd1;
                    if (tick_q == BIT_LAST) state_q <= rx_v ? S_IDLE : S_BREAK;
                end
                S_BREAK:
                    if (rx_v) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end

    // Push lands on the same edge as the stop-bit sample, so it is decoded rather than registered.
    assign stop_tick = bit_clk4x && state_q == S_STOP && tick_q == BIT_LAST;
    assign push      = stop_tick && rx_v;
    assign ferr      = stop_tick && !rx_v;
    assign pop       = data_read && !dr_q;
    assign ovf       = push && full && !pop;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (rxdata),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    always_comb begin
        overrun_d   = ovf  ? 1'b1 : err_clr ? 1'b0 : overrun_q;
        frame_err_d = ferr ? 1'b1 : err_clr ? 1'b0 : frame_err_q;
        rts_d       = CW'(FIFO_DEPTH) - count <= CW'(RTS_MARGIN);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dr_q        <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rts_q       <= 1'b0;
        end else begin
            dr_q        <= data_read;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rts_q       <= rts_d;
        end

    assign rxrecv    = !empty;
    assign rts       = rts_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
